// File: rtl/l2_bias_relu_quant_if.sv
// rtl/l2_bias_relu_quant_if.sv - layer-2 output stage bus: bias writes, accumulator stream, activations, done pulses
interface l2_bias_relu_quant_if #(
  parameter int DW = 20,
  parameter int BW = 16,
  parameter int OW = 8
);
  logic                 bias_wr_en;
  logic [2:0]           bias_wr_addr;
  logic signed [BW-1:0] bias_wr_data;
  logic                 conv_valid;
  logic                 conv_vbit;
  logic signed [DW-1:0] conv_data;
  logic [2:0]           bias_sel;
  logic [OW-1:0]        act_data;
  logic                 act_vbit;
  logic                 chan_done;
  logic                 layer_done;

  modport master (
    output bias_wr_en, bias_wr_addr, bias_wr_data,
    output conv_valid, conv_vbit, conv_data, bias_sel,
    input  act_data, act_vbit, chan_done, layer_done
  );

  modport slave (
    input  bias_wr_en, bias_wr_addr, bias_wr_data,
    input  conv_valid, conv_vbit, conv_data, bias_sel,
    output act_data, act_vbit, chan_done, layer_done
  );
endinterface

// File: rtl/l2_bias_relu_quant.sv
// rtl/l2_bias_relu_quant.sv - bias add, ReLU, round-shift requantise and saturate, with per-channel/layer completion
module l2_bias_relu_quant #(
  parameter int DW    = 20,
  parameter int BW    = 16,
  parameter int OW    = 8,
  parameter int SHIFT = 8
) (
  input logic clk,
  input logic rstn,
  l2_bias_relu_quant_if.slave bus
);
  localparam logic [8:0]  OUT_LAST = 9'd299;
  localparam logic [DW:0] HALF     = (DW+1)'(1 << (SHIFT - 1));
  localparam logic [DW:0] MAXQ     = (DW+1)'((1 << OW) - 1);

  logic signed [BW-1:0] bias [8];
  logic signed [DW:0]   s1;
  logic                 v1;
  logic [OW-1:0]        act_data_q;
  logic                 act_vbit_q;
  logic                 chan_done_q;
  logic                 layer_done_q;
  logic [8:0]           out_cnt;
  logic [2:0]           chan_cnt;

  logic [DW:0]   relu;
  logic [DW:0]   rounded;
  logic [DW:0]   q;
  logic [OW-1:0] sat;

  // S1 is at most 2^DW - 1 + 2^(BW-1) so R + HALF never overflows DW+1 bits
  always_comb begin
    relu    = s1[DW] ? '0 : $unsigned(s1);
    rounded = relu + HALF;
    q       = rounded >> SHIFT;
    sat     = (q > MAXQ) ? {OW{1'b1}} : q[OW-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) bias[i] <= '0;
      s1           <= '0;
      v1           <= 1'b0;
      act_data_q   <= '0;
      act_vbit_q   <= 1'b0;
      chan_done_q  <= 1'b0;
      layer_done_q <= 1'b0;
      out_cnt      <= '0;
      chan_cnt     <= '0;
    end else begin
      if (bus.bias_wr_en) bias[bus.bias_wr_addr] <= bus.bias_wr_data;
      // the read below sees the pre-write bias on a same-cycle collision
      if (bus.conv_vbit && bus.conv_valid)
        s1 <= (DW+1)'(bus.conv_data) + (DW+1)'(bias[bus.bias_sel]);
      if (v1 && bus.conv_valid) act_data_q <= sat;

      if (!bus.conv_valid) begin
        v1           <= 1'b0;
        act_vbit_q   <= 1'b0;
        chan_done_q  <= 1'b0;
        layer_done_q <= 1'b0;
        out_cnt      <= '0;
        chan_cnt     <= '0;
      end else begin
        v1           <= bus.conv_vbit;
        act_vbit_q   <= v1;
        chan_done_q  <= act_vbit_q && (out_cnt == OUT_LAST);
        layer_done_q <= act_vbit_q && (out_cnt == OUT_LAST) && (chan_cnt == 3'd7);
        if (act_vbit_q) begin
          if (out_cnt == OUT_LAST) begin
            out_cnt  <= '0;
            chan_cnt <= chan_cnt + 3'd1;
          end else begin
            out_cnt <= out_cnt + 9'd1;
          end
        end
      end
    end
  end

  assign bus.act_data   = act_data_q;
  assign bus.act_vbit   = act_vbit_q;
  assign bus.chan_done  = chan_done_q;
  assign bus.layer_done = layer_done_q;
endmodule

// File: tb/tb_l2_bias_relu_quant.sv
// tb/tb_l2_bias_relu_quant.sv - directed vector bench for l2_bias_relu_quant
module tb_l2_bias_relu_quant;
  localparam int DW = 20;
  localparam int BW = 16;
  localparam int OW = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  l2_bias_relu_quant_if #(.DW(DW), .BW(BW), .OW(OW)) bus ();

  l2_bias_relu_quant #(.DW(DW), .BW(BW), .OW(OW), .SHIFT(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] addr;
    int         bias;
    int         data;
    int         exp;
  } vec_t;

  vec_t vecs[10];

  // Reference model of the done pulses, updated mid-cycle from the value the next edge will sample
  int  m_out = 0, m_chan = 0;
  logic pend_cd = 1'b0, pend_ld = 1'b0;
  int  cd_count = 0, ld_count = 0, vo_count = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      m_out = 0; m_chan = 0; pend_cd = 1'b0; pend_ld = 1'b0;
    end else begin
      check("chan_done_timing", 32'(bus.chan_done), 32'(pend_cd));
      check("layer_done_timing", 32'(bus.layer_done), 32'(pend_ld));
      if (bus.chan_done)  cd_count++;
      if (bus.layer_done) ld_count++;
      if (bus.act_vbit)   vo_count++;
      if (!bus.conv_valid) begin
        m_out = 0; m_chan = 0; pend_cd = 1'b0; pend_ld = 1'b0;
      end else begin
        pend_cd = bus.act_vbit && (m_out == 299);
        pend_ld = pend_cd && (m_chan == 7);
        if (bus.act_vbit) begin
          if (m_out == 299) begin
            m_out  = 0;
            m_chan = (m_chan + 1) % 8;
          end else begin
            m_out++;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input int data, input logic [2:0] sel);
    bus.conv_data = DW'(data);
    bus.bias_sel  = sel;
    bus.conv_vbit = 1'b1;
    step();
    bus.conv_vbit = 1'b0;
  endtask

  initial begin
    int cd0, ld0, vo0, n;
    vecs[0] = '{3'd3, -200,    1000,    3};
    vecs[1] = '{3'd0, 100,     -500,    0};
    vecs[2] = '{3'd0, 100,     100000,  255};
    vecs[3] = '{3'd0, -32768,  -524288, 0};
    vecs[4] = '{3'd1, 0,       383,     1};
    vecs[5] = '{3'd1, 0,       384,     2};
    vecs[6] = '{3'd2, 32767,   524287,  255};
    vecs[7] = '{3'd6, -1,      65152,   254};
    vecs[8] = '{3'd6, -1,      65153,   255};
    vecs[9] = '{3'd4, -1,      1,       0};

    rstn             = 1'b0;
    bus.bias_wr_en   = 1'b0;
    bus.bias_wr_addr = '0;
    bus.bias_wr_data = '0;
    bus.conv_valid   = 1'b0;
    bus.conv_vbit    = 1'b0;
    bus.conv_data    = '0;
    bus.bias_sel     = '0;
    step();
    step();
    check("reset_data", 32'(bus.act_data), 0);
    check("reset_vbit", 32'(bus.act_vbit), 0);
    check("reset_chan_done", 32'(bus.chan_done), 0);
    check("reset_layer_done", 32'(bus.layer_done), 0);
    rstn           = 1'b1;
    bus.conv_valid = 1'b1;
    step();
    check("idle_data", 32'(bus.act_data), 0);

    foreach (vecs[i]) begin
      bus.bias_wr_en   = 1'b1;
      bus.bias_wr_addr = vecs[i].addr;
      bus.bias_wr_data = BW'(vecs[i].bias);
      step();
      bus.bias_wr_en = 1'b0;
      send(vecs[i].data, vecs[i].addr);
      check($sformatf("vec%0d_latency_low", i), 32'(bus.act_vbit), 0);
      step();
      check($sformatf("vec%0d_vbit", i), 32'(bus.act_vbit), 1);
      check($sformatf("vec%0d_data", i), 32'(bus.act_data), 32'(vecs[i].exp));
      step();
      check($sformatf("vec%0d_vbit_drop", i), 32'(bus.act_vbit), 0);
      check($sformatf("vec%0d_data_hold", i), 32'(bus.act_data), 32'(vecs[i].exp));
    end

    // write/read collision on bias[5]
    bus.bias_wr_en   = 1'b1;
    bus.bias_wr_addr = 3'd5;
    bus.bias_wr_data = BW'(10);
    step();
    bus.bias_wr_data = BW'(1000);
    bus.conv_data    = DW'(246);
    bus.bias_sel     = 3'd5;
    bus.conv_vbit    = 1'b1;
    step();
    bus.bias_wr_en = 1'b0;
    step();
    bus.conv_vbit = 1'b0;
    check("collision_old_vbit", 32'(bus.act_vbit), 1);
    check("collision_old_data", 32'(bus.act_data), 1);
    step();
    check("collision_new_vbit", 32'(bus.act_vbit), 1);
    check("collision_new_data", 32'(bus.act_data), 5);

    // full layer with random single-cycle gaps
    bus.conv_valid = 1'b0;
    step();
    bus.conv_valid = 1'b1;
    cd0 = cd_count; ld0 = ld_count; vo0 = vo_count;
    n = 0;
    while (n < 2400) begin
      if ($urandom_range(0, 3) == 0) step();
      send(int'($urandom_range(0, 100000)), 3'($urandom_range(0, 7)));
      n++;
    end
    repeat (4) step();
    check("layer_outputs", 32'(vo_count - vo0), 2400);
    check("layer_chan_done_count", 32'(cd_count - cd0), 8);
    check("layer_layer_done_count", 32'(ld_count - ld0), 1);
    check("layer_out_cnt_end", 32'(dut.out_cnt), 0);
    check("layer_chan_cnt_end", 32'(dut.chan_cnt), 0);

    // flush after 150 outputs with one sample still in stage 1
    cd0 = cd_count; vo0 = vo_count;
    for (int i = 0; i < 151; i++) begin
      bus.conv_data = DW'(1000 + i);
      bus.bias_sel  = 3'd1;
      bus.conv_vbit = 1'b1;
      step();
    end
    bus.conv_vbit  = 1'b0;
    check("flush_v1_pending", 32'(dut.v1), 1);
    bus.conv_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_vbit", 32'(bus.act_vbit), 0);
    end
    check("flush_outputs", 32'(vo_count - vo0), 150);
    bus.conv_valid = 1'b1;
    vo0 = vo_count;
    for (int i = 0; i < 299; i++) send(i, 3'd2);
    repeat (4) step();
    check("flush_no_early_chan_done", 32'(cd_count - cd0), 0);
    send(7, 3'd2);
    repeat (4) step();
    check("flush_fresh_outputs", 32'(vo_count - vo0), 300);
    check("flush_chan_done_after_300", 32'(cd_count - cd0), 1);

    // asynchronous reset while an output is valid
    bus.conv_data = DW'(1000);
    bus.bias_sel  = 3'd3;
    bus.conv_vbit = 1'b1;
    step();
    step();
    check("prereset_vbit", 32'(bus.act_vbit), 1);
    check("prereset_data", 32'(bus.act_data), 3);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset_data", 32'(bus.act_data), 0);
    check("async_reset_vbit", 32'(bus.act_vbit), 0);
    check("async_reset_chan_done", 32'(bus.chan_done), 0);
    check("async_reset_layer_done", 32'(bus.layer_done), 0);
    bus.conv_vbit = 1'b0;
    step();
    step();
    rstn = 1'b1;
    send(256, 3'd3);
    step();
    check("post_reset_vbit", 32'(bus.act_vbit), 1);
    check("post_reset_bias_zero", 32'(bus.act_data), 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/l2_bias_relu_quant.md
# l2_bias_relu_quant

Layer-2 post-convolution output stage. Consumes the layer-2 convolution accumulator stream together with the bias-select index produced by the layer-2 bias-mux controller. Each valid result goes through bias add, ReLU, round-and-shift requantisation and unsigned saturation. The block also holds the 8-entry bias register file that the CPU writes, and signals per-channel and per-layer completion to the layer sequencer.

## Interface
- DW, 20: signed accumulator width of ConvData_i
- BW, 16: signed bias width
- OW, 8: unsigned output width
- SHIFT, 8: requantisation right-shift, 1..DW-1
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- BiasWrEn_i  in  1  bias register write strobe
- BiasWrAddr_i  in  3  bias register index
- BiasWrData_i  in  BW  signed bias value
- ConvValid_i  in  1  layer-2 convolution active; low = idle/flush
- vbit_i  in  1  ConvData_i valid this cycle
- ConvData_i  in  DW  signed accumulator result
- BiasSel_i  in  3  channel index from the bias-mux controller, sampled with vbit_i
- Data_o  out  OW  requantised activation
- vbit_o  out  1  Data_o valid
- ChanDone_o  out  1  one-cycle pulse: 300 outputs of current channel emitted
- LayerDone_o  out  1  one-cycle pulse: all 8 channels emitted

## Operation
- Bias file: 8 x BW registers, all reset to 0. Written on clk when BiasWrEn_i=1, regardless of ConvValid_i.
- Stage 1 (registered), on vbit_i & ConvValid_i: S1 = sext(ConvData_i, DW+1) + sext(Bias[BiasSel_i], DW+1). S1 is signed, DW+1 bits, and cannot overflow.
- Same-cycle write and read of the same bias index: stage 1 uses the OLD value. The new value applies from the next vbit_i.
- Stage 2 (registered):
  - R = (S1 < 0) ? 0 : S1
  - Q = (R + 2^(SHIFT-1)) >> SHIFT
  - Data_o = (Q > 2^OW-1) ? 2^OW-1 : Q[OW-1:0]
- vbit pipeline: v1 <= vbit_i & ConvValid_i; vbit_o <= v1 & ConvValid_i.
- Data_o holds its last value when vbit_o=0.
- OutCnt (9 bits, 0..299):
  - Increments on each cycle with vbit_o=1.
  - On the 300th output (OutCnt=299 & vbit_o), it wraps to 0 and ChanDone_o pulses on the next cycle.
- ChanCnt (3 bits, 0..7):
  - Increments on each wrap of OutCnt.
  - The wrap from 7 to 0 also pulses LayerDone_o, in the same cycle as that ChanDone_o.
- ConvValid_i=0 clears v1, vbit_o, OutCnt and ChanCnt on the next edge. Data path registers and bias file are not cleared. A pending ChanDone_o/LayerDone_o pulse is suppressed.
- BiasSel_i is used only for bias lookup. Channel counting is internal and independent of BiasSel_i.

## Timing
- Reset values:
  - Data_o = 0; vbit_o = 0; ChanDone_o = 0; LayerDone_o = 0.
  - All bias registers, OutCnt and ChanCnt = 0.
- Latency: vbit_i at edge N produces vbit_o/Data_o valid after edge N+2.
- Throughput: one result per cycle. No backpressure; the consumer must accept every vbit_o.
- ChanDone_o/LayerDone_o: asserted for exactly one cycle, one cycle after the qualifying vbit_o.
- Reset asserted mid-stream: all state returns to reset values immediately (asynchronous). In-flight results are lost.
- Gaps in vbit_i with ConvValid_i=1: pipeline and counters hold. No spurious vbit_o.

## Test plan
- Reset, then bias write: write Bias[3]=-200, then ConvData_i=1000, BiasSel_i=3, one vbit_i.
  - Required: Data_o=3 with vbit_o exactly 2 cycles later.
  - Before the write, all outputs are 0.
- ReLU and saturation: Bias[0]=100.
  - ConvData_i=-500 -> Data_o=0.
  - ConvData_i=100000 -> Data_o=255.
  - ConvData_i=-524288, Bias[0]=-32768 -> 0, with no wrap.
- Write/read collision: Bias[5]=10; same cycle write Bias[5]=1000 and vbit_i with ConvData_i=246, BiasSel_i=5.
  - Required: Data_o=1, i.e. (256+128)>>8.
  - Next sample with ConvData_i=246 -> Data_o=5, i.e. (1246+128)>>8.
- Full layer: 2400 back-to-back vbit_i with random 1-cycle gaps.
  - Required: ChanDone_o pulses exactly 8 times, each one cycle after every 300th vbit_o.
  - LayerDone_o pulses once, coincident with the 8th ChanDone_o.
  - Counters end at 0.
- Flush: drop ConvValid_i after 150 outputs while v1=1, then restart.
  - Required: no vbit_o for the flushed sample.
  - The next ChanDone_o comes after 300 fresh outputs.
- Async reset mid-stream: assert rstn=0 between edges while vbit_o=1.
  - Required: all outputs 0 immediately.
  - Bias registers read back as 0, shown by ConvData_i=256 -> Data_o=1 after restart.
